// File: rtl/wam_pkg.sv
// rtl/wam_pkg.sv - whack-a-mole shared encodings, difficulty tables and LFSR constants
package wam_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        OVER = 2'b10
    } wam_state_t;

    // Lifetime counters must hold the longest lifetime (100 ticks)
    localparam int LIFE_W = 7;

    // Fibonacci feedback taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Indexed by latched difficulty 0 (easy) .. 3 (hard)
    localparam logic [5:0]        SPAWN_TICKS [4] = '{6'd50, 6'd35, 6'd20, 6'd10};
    localparam logic [LIFE_W-1:0] LIFE_TICKS  [4] = '{7'd100, 7'd70, 7'd45, 7'd25};
    localparam logic [2:0]        MAX_MOLES   [4] = '{3'd1, 3'd2, 3'd3, 3'd4};

endpackage

// File: rtl/wam_tick_gen.sv
// rtl/wam_tick_gen.sv - game tick divider producing a one-cycle pulse every TICK_DIV enabled clocks
module wam_tick_gen #(
    parameter int TICK_DIV = 500000
) (
    input  logic clk,
    input  logic clr_n,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);
    localparam int              CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Divider counts only while enabled and restarts from zero on sync_clr
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_cnt <= '0;
        end else if (sync_clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/wam_game_core.sv
// rtl/wam_game_core.sv - whack-a-mole game engine; WAM_PENALTY_EN enables wrong-tap score penalty
module wam_game_core
    import wam_pkg::*;
#(
    parameter int          N_HOLES    = 8,
    parameter int          TICK_DIV   = 500000,
    parameter int          GAME_TICKS = 3000,
    parameter int          SCORE_W    = 12,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    localparam int         TL_W       = $clog2(GAME_TICKS + 1)
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               start,
    input  logic [1:0]         difficulty,
    input  logic [N_HOLES-1:0] tap,
    output logic [N_HOLES-1:0] holes,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         escapes,
    output logic [TL_W-1:0]    time_left,
    output logic [1:0]         state
);
    localparam int SCORE_MAX = (1 << SCORE_W) - 1;

    wam_state_t         r_state, w_state_nxt;
    logic               r_start_s1, r_start_s2, r_start_d;
    logic [N_HOLES-1:0] r_tap_s1, r_tap_s2, r_tap_d;
    logic [15:0]        r_lfsr;
    logic [1:0]         r_d_lat;
    logic [N_HOLES-1:0] r_holes;
    logic [LIFE_W-1:0]  r_life [N_HOLES];
    logic [5:0]         r_spawn_cnt;
    logic [SCORE_W-1:0] r_score;
    logic [7:0]         r_escapes;
    logic [TL_W-1:0]    r_time_left;

    logic               w_start_edge, w_play_entry, w_round_end, w_tick, w_tick_en, w_spawn_due;
    logic [N_HOLES-1:0] w_tap_edge, w_cand_oh, w_hit, w_expire, w_spawn_mask;
    logic [SCORE_W-1:0] w_score_nxt;
    logic [7:0]         w_esc_nxt;
    int                 w_max_moles, w_score_sum, w_esc_sum;

    assign w_start_edge = r_start_s2 & ~r_start_d;
    assign w_tap_edge   = r_tap_s2 & ~r_tap_d;
    assign w_tick_en    = (r_state == PLAY);

`ifdef WAM_PENALTY_EN
    logic [N_HOLES-1:0] w_wrong;
    assign w_wrong = (r_state == PLAY) ? (w_tap_edge & ~r_holes) : '0;
`endif

    wam_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk      (clk),
        .clr_n    (clr_n),
        .en       (w_tick_en),
        .sync_clr (w_play_entry),
        .tick     (w_tick)
    );

    // Two-flop synchronisers plus edge registers for the asynchronous buttons
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_start_s1 <= 1'b0;
            r_start_s2 <= 1'b0;
            r_start_d  <= 1'b0;
            r_tap_s1   <= '0;
            r_tap_s2   <= '0;
            r_tap_d    <= '0;
        end else begin
            r_start_s1 <= start;
            r_start_s2 <= r_start_s1;
            r_start_d  <= r_start_s2;
            r_tap_s1   <= tap;
            r_tap_s2   <= r_tap_s1;
            r_tap_d    <= r_tap_s2;
        end
    end

    // Free-running LFSR so player timing randomises mole placement
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
        end
    end

    // Game state register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start edges in PLAY are deliberately ignored
    always_comb begin
        w_state_nxt  = r_state;
        w_play_entry = 1'b0;
        w_round_end  = 1'b0;
        case (r_state)
            IDLE, OVER: begin
                if (w_start_edge) begin
                    w_state_nxt  = PLAY;
                    w_play_entry = 1'b1;
                end
            end
            PLAY: begin
                if (w_tick && (r_time_left == TL_W'(1))) begin
                    w_state_nxt = OVER;
                    w_round_end = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Per-hole events this cycle: hits, expiries and the spawn candidate
    always_comb begin
        w_cand_oh    = '0;
        w_hit        = '0;
        w_expire     = '0;
        w_spawn_mask = '0;
        w_max_moles  = (int'(MAX_MOLES[r_d_lat]) < N_HOLES) ? int'(MAX_MOLES[r_d_lat]) : N_HOLES;
        w_spawn_due  = w_tick && (r_spawn_cnt == SPAWN_TICKS[r_d_lat] - 6'd1);
        for (int i = 0; i < N_HOLES; i++) begin
            if ((r_lfsr[7:0] % 8'(N_HOLES)) == 8'(i)) w_cand_oh[i] = 1'b1;
            if (w_tick && r_holes[i] && (r_life[i] == LIFE_W'(1))) w_expire[i] = 1'b1;
        end
        if (r_state == PLAY) begin
            w_hit = w_tap_edge & r_holes;
            if (w_spawn_due && ((w_cand_oh & r_holes) == '0) && ($countones(r_holes) < w_max_moles))
                w_spawn_mask = w_cand_oh;
        end
    end

    // Net score and escape updates with saturation; a hit masks a same-cycle expiry
    always_comb begin
        w_score_sum = int'(r_score) + $countones(w_hit);
`ifdef WAM_PENALTY_EN
        w_score_sum = w_score_sum - $countones(w_wrong);
`endif
        if (w_score_sum < 0)              w_score_nxt = '0;
        else if (w_score_sum > SCORE_MAX) w_score_nxt = SCORE_W'(SCORE_MAX);
        else                              w_score_nxt = SCORE_W'(w_score_sum);
        w_esc_sum = int'(r_escapes) + $countones(w_expire & ~w_hit);
        w_esc_nxt = (w_esc_sum > 255) ? 8'hFF : 8'(w_esc_sum);
    end

    // Round datapath: clear on entry, update during PLAY, freeze otherwise
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_holes     <= '0;
            r_score     <= '0;
            r_escapes   <= '0;
            r_time_left <= '0;
            r_spawn_cnt <= '0;
            r_d_lat     <= '0;
            for (int i = 0; i < N_HOLES; i++) r_life[i] <= '0;
        end else if (w_play_entry) begin
            r_holes     <= '0;
            r_score     <= '0;
            r_escapes   <= '0;
            r_time_left <= TL_W'(GAME_TICKS);
            r_spawn_cnt <= '0;
            r_d_lat     <= difficulty;
            for (int i = 0; i < N_HOLES; i++) r_life[i] <= '0;
        end else if (r_state == PLAY) begin
            r_holes   <= w_round_end ? '0 : ((r_holes & ~(w_hit | w_expire)) | w_spawn_mask);
            r_score   <= w_score_nxt;
            r_escapes <= w_esc_nxt;
            if (w_tick) begin
                r_time_left <= r_time_left - 1'b1;
                r_spawn_cnt <= w_spawn_due ? '0 : r_spawn_cnt + 6'd1;
            end
            for (int i = 0; i < N_HOLES; i++) begin
                if (w_spawn_mask[i])
                    r_life[i] <= LIFE_TICKS[r_d_lat];
                else if (w_tick && r_holes[i] && (r_life[i] != '0))
                    r_life[i] <= r_life[i] - 1'b1;
            end
        end
    end

    assign holes     = r_holes;
    assign score     = r_score;
    assign escapes   = r_escapes;
    assign time_left = r_time_left;
    assign state     = r_state;

endmodule

// File: tb/tb_wam_game_core.sv
// tb/tb_wam_game_core.sv - directed self-checking bench for wam_game_core
module tb_wam_game_core;

`ifdef WAM_PENALTY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr_n;
    logic        start;
    logic [1:0]  difficulty;
    logic [7:0]  tap;
    logic [7:0]  holes, holes2;
    logic [11:0] score;
    logic [1:0]  score2;
    logic [7:0]  escapes, escapes2;
    logic [7:0]  time_left, time_left2;
    logic [1:0]  state, state2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int maxpop = 0;
    logic [15:0] m_lfsr;

    wam_game_core #(.N_HOLES(8), .TICK_DIV(4), .GAME_TICKS(200), .SCORE_W(12), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .difficulty(difficulty), .tap(tap),
        .holes(holes), .score(score), .escapes(escapes), .time_left(time_left), .state(state)
    );

    wam_game_core #(.N_HOLES(8), .TICK_DIV(4), .GAME_TICKS(200), .SCORE_W(2), .LFSR_SEED(16'hACE1)) dut2 (
        .clk(clk), .clr_n(clr_n), .start(start), .difficulty(difficulty), .tap(tap),
        .holes(holes2), .score(score2), .escapes(escapes2), .time_left(time_left2), .state(state2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR: x^16 + x^14 + x^13 + x^11, shifting left, seed ACE1
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic goto(input int c);
        if (cyc > c) begin
            total++;
            bad++;
            $error("FAIL goto_late observed=%0d expected=%0d", cyc, c);
        end
        while (cyc < c) begin
            @(posedge clk);
            #1;
            if ($countones(holes) > maxpop) maxpop = $countones(holes);
        end
    endtask

    function automatic int upd(input int old, input int hits, input int wrongs, input int maxv);
        int v;
        v = old + hits - (PEN ? wrongs : 0);
        if (v < 0) v = 0;
        if (v > maxv) v = maxv;
        return v;
    endfunction

    initial begin
        int a, p, p2, p3, p4, h, e1, e2;
        logic [7:0] hm;

        clr_n = 1'b0; start = 1'b0; difficulty = 2'd0; tap = '0;
        goto(3);
        chk("rst_state", state, 0);
        chk("rst_holes", holes, 0);
        chk("rst_score", score, 0);
        chk("rst_escapes", escapes, 0);
        chk("rst_time_left", time_left, 0);
        chk("rst_escapes2", escapes2, 0);
        clr_n = 1'b1;

        // Game 1: easy, no taps
        goto(5);
        difficulty = 2'd0; start = 1'b1; a = cyc; p = a + 3;
        goto(a + 2);
        chk("g1_start_latency", state, 0);
        goto(p);
        chk("g1_state_play", state, 1);
        chk("g1_time_left_init", time_left, 200);
        goto(p + 199);
        h = int'(m_lfsr[7:0]) % 8; hm = 8'(1 << h);
        chk("g1_pre_spawn_holes", holes, 0);
        chk("g1_time_left_t49", time_left, 151);
        goto(p + 200);
        chk("g1_spawn_t50", holes, 32'(hm));
        chk("g1_time_left_t50", time_left, 150);
        goto(p + 400);
        chk("g1_max1_t100", holes, 32'(hm));
        goto(p + 599);
        chk("g1_alive_t149", holes, 32'(hm));
        chk("g1_no_escape_yet", escapes, 0);
        goto(p + 600);
        chk("g1_expired_hole", holes[h], 0);
        chk("g1_escapes_t150", escapes, 1);
        goto(p + 799);
        chk("g1_state_t199", state, 1);
        chk("g1_time_left_t199", time_left, 1);
        goto(p + 800);
        chk("g1_state_over", state, 2);
        chk("g1_holes_over", holes, 0);
        chk("g1_time_left_over", time_left, 0);
        chk("g1_escapes_hold", escapes, 1);
        tap = 8'hFF;
        goto(p + 806);
        chk("g1_over_tap_score", score, 0);
        chk("g1_over_tap_state", state, 2);
        tap = '0; start = 1'b0;

        // Game 2: hard, hit every early mole, wrong taps, hit-on-expiry
        goto(p + 812);
        difficulty = 2'd3; start = 1'b1; a = cyc; p2 = a + 3;
        goto(p2);
        chk("g2_state_play", state, 1);
        chk("g2_escapes_cleared", escapes, 0);
        chk("g2_time_left_init", time_left, 200);
        e1 = 0; e2 = 0;
        for (int i = 1; i <= 5; i++) begin
            goto(p2 + 40 * i - 1);
            h = int'(m_lfsr[7:0]) % 8; hm = 8'(1 << h);
            chk("g2_pre_spawn_holes", holes, 0);
            goto(p2 + 40 * i);
            chk("g2_spawn_holes", holes, 32'(hm));
            chk("g2_spawn_holes2", holes2, 32'(hm));
            tap = hm;
            goto(p2 + 40 * i + 2);
            chk("g2_hit_latency", holes, 32'(hm));
            goto(p2 + 40 * i + 3);
            e1 = upd(e1, 1, 0, 4095); e2 = upd(e2, 1, 0, 3);
            chk("g2_hit_holes", holes, 0);
            chk("g2_hit_score", score, 32'(e1));
            chk("g2_hit_score2_sat", score2, 32'(e2));
            tap = '0;
            if (i == 1) begin
                goto(p2 + 46);
                tap = hm;
                goto(p2 + 49);
                e1 = upd(e1, 0, 1, 4095); e2 = upd(e2, 0, 1, 3);
                chk("g2_wrong_tap1", score, 32'(e1));
                tap = '0;
                goto(p2 + 52);
                tap = hm;
                goto(p2 + 55);
                e1 = upd(e1, 0, 1, 4095); e2 = upd(e2, 0, 1, 3);
                chk("g2_wrong_tap2", score, 32'(e1));
                chk("g2_wrong_tap2_s2", score2, 32'(e2));
                tap = '0;
                goto(p2 + 56);
                start = 1'b0;
                goto(p2 + 60);
                start = 1'b1;
                goto(p2 + 70);
                chk("g2_start_in_play_state", state, 1);
                chk("g2_start_in_play_time", time_left, 183);
            end
        end
        goto(p2 + 206);
        tap = 8'h03;
        goto(p2 + 209);
        e1 = upd(e1, 0, 2, 4095); e2 = upd(e2, 0, 2, 3);
        chk("g2_double_wrong", score, 32'(e1));
        chk("g2_double_wrong_s2", score2, 32'(e2));
        tap = '0;
        goto(p2 + 239);
        h = int'(m_lfsr[7:0]) % 8; hm = 8'(1 << h);
        goto(p2 + 240);
        chk("g2_spawn_t60", holes, 32'(hm));
        goto(p2 + 337);
        tap = hm;
        goto(p2 + 339);
        chk("g2_mole_alive_t84", holes[h], 1);
        chk("g2_escapes_t84", escapes, 0);
        goto(p2 + 340);
        e1 = upd(e1, 1, 0, 4095); e2 = upd(e2, 1, 0, 3);
        chk("g2_hit_expiry_hole", holes[h], 0);
        chk("g2_hit_expiry_score", score, 32'(e1));
        chk("g2_hit_expiry_score2", score2, 32'(e2));
        chk("g2_hit_expiry_escapes", escapes, 0);
        tap = '0;
        maxpop = 0;
        goto(p2 + 400);
        chk("g2_time_left_t100", time_left, 100);
        goto(p2 + 799);
        chk("g2_time_left_t199", time_left, 1);
        goto(p2 + 800);
        chk("g2_state_over", state, 2);
        chk("g2_holes_over", holes, 0);
        chk("g2_time_left2_over", time_left2, 0);
        chk("g2_state2_over", state2, 2);
        chk("g2_maxpop_le4", (maxpop <= 4), 1);
        tap = 8'hFF;
        goto(p2 + 806);
        chk("g2_over_tap_score", score, 32'(e1));
        chk("g2_over_tap_score2", score2, 32'(e2));
        tap = '0; start = 1'b0;

        // Game 3: score a hit, then reset mid-round
        goto(p2 + 812);
        difficulty = 2'd3; start = 1'b1; a = cyc; p3 = a + 3;
        goto(p3 + 39);
        h = int'(m_lfsr[7:0]) % 8; hm = 8'(1 << h);
        goto(p3 + 40);
        chk("g3_spawn", holes, 32'(hm));
        tap = hm;
        goto(p3 + 43);
        chk("g3_score", score, 1);
        tap = '0;
        goto(p3 + 50);
        #3;
        clr_n = 1'b0; start = 1'b0;
        #1;
        chk("g3_rst_state", state, 0);
        chk("g3_rst_holes", holes, 0);
        chk("g3_rst_score", score, 0);
        chk("g3_rst_time_left", time_left, 0);
        goto(p3 + 53);
        clr_n = 1'b1;

        // Game 4: first spawn after reset shows the LFSR was reseeded
        goto(p3 + 56);
        difficulty = 2'd3; start = 1'b1; a = cyc; p4 = a + 3;
        goto(p4);
        chk("g4_state_play", state, 1);
        goto(p4 + 39);
        h = int'(m_lfsr[7:0]) % 8; hm = 8'(1 << h);
        goto(p4 + 40);
        chk("g4_spawn_reseed", holes, 32'(hm));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wam_game_core.md
Name: wam_game_core

Overview:
- Parametrised whack-a-mole game engine. Replaces the fixed 8-hole generate/hit/score trio with a single core.
- Adds:
  - an explicit game FSM;
  - a round timer;
  - per-hole mole lifetimes;
  - a difficulty-limited mole count;
  - escape counting.
- Sits between the debounced switch/button inputs and the LED/7-segment display drivers.

Parameters:
- N_HOLES, 8: number of holes/tap inputs (2..16).
- TICK_DIV, 500000: clk cycles per game tick (100 Hz at 50 MHz).
- GAME_TICKS, 3000: round length in ticks (30 s).
- SCORE_W, 12: score width (binary).
- LFSR_SEED, 16'hACE1: 16-bit LFSR reset value (must be non-zero).

Ports:
- clk  in  1  system clock.
- clr_n  in  1  asynchronous active-low reset.
- start  in  1  start button, level; rising edge is used.
- difficulty  in  2  0 = easy … 3 = hard; sampled on start edge.
- tap  in  N_HOLES  hit switches, asynchronous, one per hole.
- holes  out  N_HOLES  1 = mole up.
- score  out  SCORE_W  successful hits this round.
- escapes  out  8  moles that timed out this round.
- time_left  out  clog2(GAME_TICKS+1)  ticks remaining.
- state  out  2  00 IDLE, 01 PLAY, 10 OVER.

Behaviour:
- Reset (clr_n low, async):
  - state = IDLE; holes, score, escapes, time_left, tick divider and all lifetimes = 0.
  - LFSR = LFSR_SEED.
  - start/tap synchroniser and edge registers = 0.
- Input conditioning:
  - start and each tap bit go through a 2-flop synchroniser, then a rising-edge detector.
  - A tap rising at clock edge k takes effect at edge k+3.
- LFSR: 16-bit Fibonacci (taps 16,14,13,11). Advances every clk in every state, so human timing seeds it.
- Tick: one-cycle pulse every TICK_DIV clks, counted in PLAY only. The divider clears on PLAY entry.
- FSM:
  - IDLE -> PLAY on start edge.
  - PLAY -> OVER on the tick where time_left goes 1 -> 0.
  - OVER -> PLAY on start edge.
  - start edge during PLAY is ignored.
- PLAY entry:
  - score = 0, escapes = 0, holes = 0, time_left = GAME_TICKS.
  - difficulty is latched into d_lat.
- Difficulty table, indexed by d_lat 0/1/2/3:
  - spawn interval = 50/35/20/10 ticks.
  - mole lifetime = 100/70/45/25 ticks.
  - max simultaneous moles = 1/2/3/4 (capped at N_HOLES).
- Spawn:
  - Every spawn-interval ticks, candidate hole = LFSR[7:0] mod N_HOLES.
  - If the candidate hole is empty and popcount(holes) < max, set the hole and load its lifetime counter.
  - Otherwise the spawn is skipped; there is no retry until the next interval.
- Lifetime: each tick decrements every up-mole's counter. On reaching 0 the hole clears and escapes increments (saturates at 255).
- Hit:
  - Tap edge on an up hole: hole clears and score += number of such hits in that cycle. Score saturates at 2^SCORE_W-1.
  - Tap edge on an empty hole: no effect (see optional feature).
- Simultaneous events on the same hole and cycle:
  - hit and expiry: hit wins, no escape counted.
  - spawn and tap on an empty hole: tap counts as a wrong tap; spawn proceeds.
- OVER:
  - holes forced to 0 on the transition edge.
  - Taps ignored; score, escapes and time_left (= 0) hold until the next start edge.
- clr_n asserted mid-round: immediate return to IDLE. Score is lost.

Optional Feature:
- Macro: WAM_PENALTY_EN.
- Defined:
  - A wrong tap (edge on an empty hole during PLAY) decrements score by 1 per wrong bit, floored at 0.
  - If hits and wrong taps occur in the same cycle, the net change is applied before saturation/floor.
- Undefined: wrong taps are ignored.

Decomposition:
- Package wam_pkg:
  - state encodings IDLE/PLAY/OVER;
  - difficulty tables (spawn interval, lifetime, max moles) as constant arrays;
  - LFSR tap mask;
  - lifetime counter width (7 bits).
- One sub-module: wam_tick_gen. Parameter TICK_DIV; inputs clk, clr_n, en, sync_clr; output tick, a one-cycle pulse.

Test Plan:
All tests use TICK_DIV=4, GAME_TICKS=200, N_HOLES=8.
1. Reset mid-PLAY with score=5 -> within the same cycle, state=IDLE, holes=0, score=0; after release, LFSR=16'hACE1.
2. start edge, difficulty=0, no taps -> first mole at tick 50. It escapes at tick 150 (escapes=1). At tick 200, state=OVER, holes=0.
3. Mole up on hole 3, tap[3] rises at edge k -> holes[3]=0 and score=1 at edge k+3. A second tap[3] edge leaves score=1.
4. difficulty=3, no taps -> popcount(holes) never exceeds 4 over the full round. Skipped spawns leave time_left unaffected.
5. Hit on hole 2 in the same cycle its lifetime reaches 0 -> score +1, escapes unchanged. Preload score=4095 (SCORE_W=12) plus a further hit -> score stays 4095.
6. WAM_PENALTY_EN defined: score=0 and a tap on an empty hole -> score stays 0. score=3 with two wrong taps in one cycle -> score=1.
